// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register:
//   - 3-bit mode codes applied by the manual path and the burst engine
//   - burst FSM state encoding
//   - usr_next_q(): next register value for a given mode. It works on a
//     USR_MAX_W-bit container. The caller zero-extends q, d and the reset
//     value into this container, passes its real width, and truncates the
//     result back to that width.
// -----------------------------------------------------------------------------
package usr_pkg;

    // Widest register the next-state helper can handle.
    localparam int USR_MAX_W = 64;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } usr_state_t;

    // Only shifts and rotates can be run as a burst.
    function automatic logic usr_is_burst_mode(input logic [2:0] mode);
        return (mode == MODE_SHL) || (mode == MODE_SHR) ||
               (mode == MODE_ROTL) || (mode == MODE_ROTR);
    endfunction

    // The MSB of the real register sits at bit (width-1) of the container.
    // It is located with a one-hot mask, so no variable bit index is needed.
    function automatic logic [USR_MAX_W-1:0] usr_next_q(
        input logic [USR_MAX_W-1:0] q,
        input logic [2:0]           mode,
        input logic [USR_MAX_W-1:0] d,
        input logic [USR_MAX_W-1:0] rst_val,
        input logic                 sin_l,
        input logic                 sin_r,
        input int                   width
    );
        logic [USR_MAX_W-1:0] msb;
        logic [USR_MAX_W-1:0] r;
        msb = {{(USR_MAX_W-1){1'b0}}, 1'b1} << (width - 1);
        case (mode)
            MODE_LOAD: r = d;
            MODE_SHL:  r = {q[USR_MAX_W-2:0], sin_l};
            MODE_SHR:  r = ((q >> 1) & ~msb) | (sin_r ? msb : '0);
            MODE_ROTL: r = {q[USR_MAX_W-2:0], |(q & msb)};
            MODE_ROTR: r = ((q >> 1) & ~msb) | (q[0] ? msb : '0);
            MODE_CLR:  r = rst_val;
            default:   r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// usr_burst_ctrl
// Burst engine for univ_shift_reg: IDLE -> RUN (burst_len edges) -> DONE -> IDLE.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              one-cycle burst request
//   burst_len[CNT_W]   number of shifts to perform
//   mode[3]            operation code; latched as burst_mode when a burst starts
//   busy               high while in RUN (a burst shift happens on every edge)
//   done               high for the single DONE cycle
//   accept             combinational: a burst is being accepted on this edge
//   burst_mode[3]      operation latched at burst start
// -----------------------------------------------------------------------------
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [2:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             accept,
    output logic [2:0]       burst_mode
);

    usr_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       burst_mode_n;

    // A start is honoured in DONE as well as IDLE, which allows back-to-back bursts.
    assign accept = start && (state != ST_RUN) && (burst_len != '0) &&
                    usr_is_burst_mode(mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            burst_mode <= MODE_HOLD;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            burst_mode <= burst_mode_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        burst_mode_n = burst_mode;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_n      = ST_RUN;
                    cnt_n        = burst_len;
                    burst_mode_n = mode;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_n = cnt - 1'b1;
                if (cnt == CNT_W'(1)) state_n = ST_DONE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Both flags are decoded straight from the state register.
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// WIDTH-bit register with per-cycle hold/load/shift/rotate/clear and an
// autonomous burst engine that runs N shifts or rotates after one start pulse.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (q <= RST_VAL)
//   en                 manual-mode enable
//   mode[3]            operation code (see usr_pkg)
//   d[WIDTH]           parallel load data
//   sin_l, sin_r       serial inputs for SHL (into LSB) and SHR (into MSB)
//   start              burst request
//   burst_len[CNT_W]   burst length
//   q[WIDTH]           register contents
//   sout_l, sout_r     q[WIDTH-1] and q[0] (combinational)
//   busy, done         burst running / one-cycle completion pulse
// WIDTH must be in the range 2..USR_MAX_W.
// -----------------------------------------------------------------------------
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    logic                 accept;
    logic [2:0]           burst_mode;
    logic [2:0]           op;
    logic                 apply;
    logic [USR_MAX_W-1:0] q_ext, d_ext, rv_ext;
    logic [WIDTH-1:0]     q_n;

    usr_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .accept     (accept),
        .burst_mode (burst_mode)
    );

    // The burst overrides en/mode. The edge that accepts a burst does
    // nothing to q, so the first burst shift lands on the following edge.
    always_comb begin
        op    = mode;
        apply = en;
        if (busy) begin
            op    = burst_mode;
            apply = 1'b1;
        end else if (accept) begin
            apply = 1'b0;
        end
    end

    always_comb begin
        q_ext  = '0;
        d_ext  = '0;
        rv_ext = '0;
        q_ext[WIDTH-1:0]  = q;
        d_ext[WIDTH-1:0]  = d;
        rv_ext[WIDTH-1:0] = RST_VAL;
        q_n = WIDTH'(usr_next_q(q_ext, op, d_ext, rv_ext, sin_l, sin_r, WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        q <= RST_VAL;
        else if (apply) q <= q_n;
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit async-reset D flip-flop: a WIDTH-bit register with per-cycle mode control (hold, load, shift, rotate, clear).
- Adds an autonomous burst engine that performs N shifts or rotates after a single start pulse.
- Used as the storage and serialiser primitive in the team's flops and latches library, for example for SIPO/PISO, LED chasers and bit-serial links.

Parameters:
- WIDTH, 8, register width in bits; must be at least 2.
- RST_VAL, 0, value loaded into q on reset and on CLR; WIDTH bits.
- CNT_W, 4, width of burst_len; maximum burst is 2^CNT_W - 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  manual-mode clock enable; when 0, q holds (burst is unaffected).
- mode  in  3  operation code; encodings are listed under Behaviour.
- d  in  WIDTH  parallel load data.
- sin_l  in  1  serial in at the LSB, used by SHL.
- sin_r  in  1  serial in at the MSB, used by SHR.
- start  in  1  one-cycle request to begin a burst.
- burst_len  in  CNT_W  number of shifts in the burst.
- q  out  WIDTH  register contents.
- sout_l  out  1  equals q[WIDTH-1].
- sout_r  out  1  equals q[0].
- busy  out  1  high while a burst is running.
- done  out  1  one-cycle pulse after the last burst shift.

Behaviour:
- Reset (rst=1, asynchronous, with immediate effect on all outputs):
  - q=RST_VAL, busy=0, done=0.
  - The internal counter clears and the FSM returns to IDLE.
  - Reset may arrive mid-burst; the burst is aborted and done is not produced.
- Mode codes:
  - 000 HOLD.
  - 001 LOAD: q<=d.
  - 010 SHL: q<={q[W-2:0],sin_l}.
  - 011 SHR: q<={sin_r,q[W-1:1]}.
  - 100 ROTL: q<={q[W-2:0],q[W-1]}.
  - 101 ROTR: q<={q[0],q[W-1:1]}.
  - 110 CLR: q<=RST_VAL.
  - 111 HOLD (reserved).
- Manual operation (FSM in IDLE):
  - Each rising edge with en=1 applies mode; en=0 holds.
  - Latency is one clock: the new q is visible after the edge.
  - sout_l and sout_r are combinational from q.
- Burst FSM states are IDLE, RUN, and DONE.
- IDLE -> RUN:
  - Triggered by start=1 with burst_len!=0 and a mode in {SHL, SHR, ROTL, ROTR}.
  - Latches the mode into burst_mode and sets cnt=burst_len.
  - The manual operation for that cycle is suppressed; no shift happens on the start edge.
  - busy=1 from the next cycle.
- Start ignored in IDLE:
  - start with burst_len=0 is ignored: no busy, no done, manual mode applies normally.
  - start with any other mode (LOAD, CLR, HOLD) is ignored as a burst; the manual mode still applies when en=1.
- RUN:
  - Each edge applies burst_mode regardless of en, mode, and d, and decrements cnt.
  - sin_l and sin_r are sampled live each cycle.
  - When cnt is 1 at the edge, the last shift occurs and the FSM goes to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - The manual path is live in this cycle: en and mode are applied.
  - The FSM returns to IDLE; a start in DONE is accepted as in IDLE.
- start while busy is ignored; it is neither queued nor restarted.
- The burst takes exactly burst_len shift edges. The first shift is at edge start+1; done is high in the cycle after the last shift.
- Rotates by multiples of WIDTH return q to its original value. Bursts are allowed to exceed WIDTH.
- All outputs are registered except sout_l and sout_r.

Decomposition:
- Package usr_pkg holds:
  - a localparam for each 3-bit mode code (MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_CLR);
  - FSM state codes ST_IDLE, ST_RUN, ST_DONE;
  - a function for next-q given (q, mode, d, sin_l, sin_r).
- One sub-module, usr_burst_ctrl, holds the FSM, the CNT_W down-counter, and the busy/done/burst_mode outputs.
- The top level contains the data register and the mode mux.

Test Plan:
1. Reset and load: assert rst mid-cycle with WIDTH=8 and RST_VAL=8'hA5 -> q=A5 immediately, with no clock needed. Release rst, then LOAD d=3C with en=1 -> q=3C after one edge. With en=0, q holds 3C.
2. Manual shifts: q=81. SHL with sin_l=0 -> 02. SHR with sin_r=1 -> 81 → C0. ROTL from 81 -> 03. ROTR from 81 -> C0. CLR -> A5. Check sout_l=q[7] and sout_r=q[0] at every step.
3. Burst rotate: q=01, start with ROTL and burst_len=3, en=0.
   - busy is high for 3 cycles; q goes 02, 04, 08.
   - done is a single pulse in the following cycle, then busy=0.
   - Toggling mode and d during RUN has no effect.
4. Burst edge cases:
   - burst_len=0 with start -> no busy, no done.
   - start with mode LOAD -> no burst; a normal load when en=1.
   - start during RUN -> ignored; the total shift count stays the original burst_len.
   - burst_len=8 with ROTR on 5A -> q=5A at done.
5. Reset mid-burst: start SHR with burst_len=10, assert rst after 4 shifts -> q=A5, busy=0, and no done pulse. A new start after release runs the full 10 shifts.
6. Back-to-back: start asserted in the DONE cycle -> a new burst is accepted and busy rises the next cycle. Repeat with WIDTH=16 and CNT_W=5 for a 31-shift SHL with sin_l=1 -> q=FFFF.
